tdm_receiver8: RTL and testbench

TDM_RECEIVER8 -- requirements
Module: tdm_receiver8

---
 rtl/tdm_receiver8_pkg.sv | 23 ++
 rtl/slot_counter3.sv | 38 +++
 rtl/tdm_receiver8.sv | 114 +++++++++++
 tb/tb_tdm_receiver8.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_receiver8_pkg.sv
// Shared definitions for the 8-slot TDM receiver: FSM encoding, slot geometry
// and the line-fault test applied to the distributor lines.
package tdm_receiver8_pkg;

    localparam int SLOTS  = 8;
    localparam int SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Unselected distributor lines idle high, so any zero outside the selected slot is a fault.
    function automatic logic line_fault(input logic [SLOTS-1:0] lines, input slot_t sel);
        logic [SLOTS-1:0] sel_mask;
        sel_mask = SLOTS'(1) << sel;
        return (lines | sel_mask) != {SLOTS{1'b1}};
    endfunction

endpackage

// File: rtl/slot_counter3.sv
// 3-bit wrapping slot counter with synchronous clear, enable and a
// terminal-count flag raised while the count sits at 7.
module slot_counter3
    import tdm_receiver8_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  en_i,
    output slot_t count_o,
    output logic  tc_o
);

    slot_t count_q, count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == 3'd7);

endmodule

// File: rtl/tdm_receiver8.sv
// TDM receiver: scans the 8 distributor slots in turn via {A,B,C}, rebuilds
// the byte in a shadow register and delivers it with a line-fault flag.
module tdm_receiver8 #(
    parameter int SLOTS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iEn,
    output logic             A,
    output logic             B,
    output logic             C,
    input  logic [SLOTS-1:0] iData,
    output logic [SLOTS-1:0] oData,
    output logic             oValid,
    output logic             oErr,
    output logic             oBusy,
    output logic [7:0]       oFrames
);

    import tdm_receiver8_pkg::*;

    state_e           state_q, state_d;
    slot_t            slot;
    logic             slot_tc;
    logic [SLOTS-1:0] shadow_q, shadow_d;
    logic             err_q, err_d;
    logic [SLOTS-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             oerr_q, oerr_d;
    logic             busy_q, busy_d;
    logic [7:0]       frames_q, frames_d;

    // Held at zero outside SCAN, so IDLE and DONE both present slot 0 and a new frame starts there.
    slot_counter3 u_slot (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q != SCAN),
        .en_i    (state_q == SCAN),
        .count_o (slot),
        .tc_o    (slot_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iEn) state_d = SCAN;
            SCAN:    if (slot_tc) state_d = DONE;
            DONE:    state_d = iEn ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        data_d   = data_q;
        oerr_d   = oerr_q;
        frames_d = frames_q;
        valid_d  = 1'b0;
        busy_d   = (state_d == SCAN);

        if (state_q == SCAN) begin
            shadow_d[slot] = iData[slot];
            err_d          = err_q | line_fault(iData, slot);
            // The last slot is folded in on the same edge, so delivery includes bit 7 and its fault check.
            if (slot_tc) begin
                data_d   = shadow_d;
                oerr_d   = err_d;
                valid_d  = 1'b1;
                frames_d = frames_q + 8'd1;
            end
        end

        if (state_q != SCAN && state_d == SCAN) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            oerr_q   <= 1'b0;
            busy_q   <= 1'b0;
            frames_q <= 8'd0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            oerr_q   <= oerr_d;
            busy_q   <= busy_d;
            frames_q <= frames_d;
        end
    end

    assign {A, B, C} = slot;
    assign oData     = data_q;
    assign oValid    = valid_q;
    assign oErr      = oerr_q;
    assign oBusy     = busy_q;
    assign oFrames   = frames_q;

endmodule

// File: tb/tb_tdm_receiver8.sv
// Self-checking bench for tdm_receiver8: behavioural 8-to-1 distributor,
// table-driven directed frames, a mid-scan reset and randomized frames through oFrames wrap.
module tb_tdm_receiver8;

    logic       clk = 1'b0;
    logic       rst;
    logic       iEn;
    logic       A, B, C;
    logic [7:0] iData;
    logic [7:0] oData;
    logic       oValid, oErr, oBusy;
    logic [7:0] oFrames;

    always #5 clk = ~clk;

    tdm_receiver8 #(.SLOTS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .iEn     (iEn),
        .A       (A),
        .B       (B),
        .C       (C),
        .iData   (iData),
        .oData   (oData),
        .oValid  (oValid),
        .oErr    (oErr),
        .oBusy   (oBusy),
        .oFrames (oFrames)
    );

    // Distributor: the selected line carries tx_byte[sel], all others idle high;
    // an optional fault pulls line fault_line low while slot fault_slot is selected.
    logic [7:0] tx_byte;
    int         fault_slot;
    int         fault_line;
    logic [2:0] sel;
    assign sel = {A, B, C};

    always_comb begin
        iData      = 8'hFF;
        iData[sel] = tx_byte[sel];
        if (fault_slot >= 0 && fault_line >= 0 && int'(sel) == fault_slot) begin
            iData[fault_line[2:0]] = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: what the receiver last delivered and how many frames it has completed.
    logic [7:0] m_data;
    logic       m_err;
    logic [7:0] m_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_err(input int fslot, input int fline);
        return (fslot >= 0) && (fline >= 0) && (fline != fslot);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_abc"},    32'({A, B, C}), 32'd0);
        check({tag, "_data"},   32'(oData),     32'h00);
        check({tag, "_valid"},  32'(oValid),    32'd0);
        check({tag, "_err"},    32'(oErr),      32'd0);
        check({tag, "_busy"},   32'(oBusy),     32'd0);
        check({tag, "_frames"}, 32'(oFrames),   32'd0);
    endtask

    // Idle cycles: nothing delivered, not busy, slot select parked at 000, last results held.
    task automatic idle(input int n);
        iEn = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_valid", 32'(oValid), 32'd0);
            check("idle_busy",  32'(oBusy),  32'd0);
            check("idle_abc",   32'({A, B, C}), 32'd0);
            check("idle_data",  32'(oData),  32'(m_data));
        end
    endtask

    // One frame: iEn sampled at edge 0, slots sampled at edges 1..8, delivery visible after edge 8.
    task automatic run_frame(input logic [7:0] d, input bit hold, input int fslot, input int fline,
                             input logic [7:0] exp_data, input bit exp_err);
        tx_byte    = d;
        fault_slot = fslot;
        fault_line = fline;
        iEn        = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) iEn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("scan_abc",   32'({A, B, C}), 32'(k));
            check("scan_busy",  32'(oBusy),  32'd1);
            check("scan_valid", 32'(oValid), 32'd0);
            check("scan_data",  32'(oData),  32'(m_data));
            check("scan_err",   32'(oErr),   32'(m_err));
            @(posedge clk);
            #1;
        end
        m_data   = exp_data;
        m_err    = exp_err;
        m_frames = m_frames + 8'd1;
        @(negedge clk);
        check("done_valid",  32'(oValid),  32'd1);
        check("done_data",   32'(oData),   32'(m_data));
        check("done_err",    32'(oErr),    32'(m_err));
        check("done_frames", 32'(oFrames), 32'(m_frames));
        check("done_busy",   32'(oBusy),   32'd0);
        check("done_abc",    32'({A, B, C}), 32'd0);
        fault_slot = -1;
        fault_line = -1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         hold;
        int         fslot;
        int         fline;
        logic [7:0] exp_data;
        bit         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'hA5, hold: 1'b0, fslot: -1, fline: -1, exp_data: 8'hA5, exp_err: 1'b0};
        vecs[1] = '{data: 8'h00, hold: 1'b1, fslot: -1, fline: -1, exp_data: 8'h00, exp_err: 1'b0};
        vecs[2] = '{data: 8'hFF, hold: 1'b1, fslot: -1, fline: -1, exp_data: 8'hFF, exp_err: 1'b0};
        vecs[3] = '{data: 8'h3C, hold: 1'b0, fslot: -1, fline: -1, exp_data: 8'h3C, exp_err: 1'b0};
        vecs[4] = '{data: 8'h81, hold: 1'b1, fslot: 2,  fline: 6,  exp_data: 8'h81, exp_err: 1'b1};
        vecs[5] = '{data: 8'h66, hold: 1'b0, fslot: -1, fline: -1, exp_data: 8'h66, exp_err: 1'b0};

        rst        = 1'b1;
        iEn        = 1'b0;
        tx_byte    = 8'h00;
        fault_slot = -1;
        fault_line = -1;
        m_data     = 8'h00;
        m_err      = 1'b0;
        m_frames   = 8'd0;

        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].hold, vecs[i].fslot, vecs[i].fline,
                      vecs[i].exp_data, vecs[i].exp_err);
            if (!vecs[i].hold) idle(3);
        end

        // Reset five cycles into a scan: frame discarded, everything back to reset values.
        tx_byte = 8'hC3;
        iEn     = 1'b1;
        @(posedge clk);
        #1;
        iEn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midscan_rst");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_data   = 8'h00;
        m_err    = 1'b0;
        m_frames = 8'd0;
        idle(3);
        run_frame(8'h5A, 1'b0, -1, -1, 8'h5A, 1'b0);
        idle(1);

        // Random frames carry the count from 1 through 255 and back to 0.
        for (int i = 0; i < 255; i++) begin
            logic [7:0] d;
            bit         hold;
            int         fs;
            int         fl;
            d    = 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            fs   = -1;
            fl   = -1;
            if ($urandom_range(0, 3) == 0) begin
                fs = int'($urandom_range(0, 7));
                fl = (fs + int'($urandom_range(1, 7))) % 8;
            end
            run_frame(d, hold, fs, fl, d, ref_err(fs, fl));
            if (!hold) idle(1);
        end
        check("frames_wrap", 32'(oFrames), 32'd0);

        iEn = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
